// File: rtl/if_stage.sv
// Instruction fetch stage: word-addressed PC, IF/ID pipeline register and a RUN/HALTED fetch FSM.
// Each cycle takes one action in priority order: reset, flush, stall, halt detect, normal fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] br_target,
    input  logic [31:0] inst_in,
    output logic [7:0]  imem_addr,
    output logic [31:0] pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q,    state_d;
    logic [31:0]      pc_q,       pc_d;
    logic [31:0]      id_pc_q,    id_pc_d;
    logic [31:0]      id_inst_q,  id_inst_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'd0;
            id_inst_q  <= 32'd0;
            id_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic; HALTED and stalled cycles fall through to the hold defaults
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        cnt_d      = cnt_q;

        if (flush) begin
            pc_d       = br_target;
            id_pc_d    = 32'd0;
            id_inst_d  = 32'd0;
            id_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else if (state_q == ST_RUN && !stall) begin
            if (inst_in == HALT_WORD) begin
                id_inst_d  = 32'd0;
                id_valid_d = 1'b0;
                state_d    = ST_HALTED;
            end else begin
                id_inst_d  = inst_in;
                id_pc_d    = pc_q;
                id_valid_d = 1'b1;
                pc_d       = pc_q + 32'd1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign imem_addr   = pc_q[7:0];
    assign pc          = pc_q;
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_valid    = id_valid_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: one instance from PC 0 for fetch/stall/flush/halt, one from PC 254 for wrap, reset-in-stall and saturation.
module tb_if_stage;

    logic        clk;
    int          n_checks;
    int          n_errors;

    logic        rst, stall, flush;
    logic [31:0] br_target, inst_in;
    logic [7:0]  imem_addr;
    logic [31:0] pc, id_pc, id_inst;
    logic        id_valid, halted;
    logic [15:0] fetch_count;

    logic        w_rst, w_stall, w_flush;
    logic [31:0] w_br_target, w_inst_in;
    logic [7:0]  w_imem_addr;
    logic [31:0] w_pc, w_id_pc, w_id_inst;
    logic        w_id_valid, w_halted;
    logic [15:0] w_fetch_count;

    logic [31:0] imem [256];
    logic [31:0] wmem [256];

    if_stage #(.RESET_PC(32'd0), .HALT_WORD(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .br_target(br_target),
        .inst_in(inst_in), .imem_addr(imem_addr), .pc(pc), .id_pc(id_pc),
        .id_inst(id_inst), .id_valid(id_valid), .halted(halted), .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(32'd254), .HALT_WORD(32'h0000_0000)) u_wrap (
        .clk(clk), .rst(w_rst), .stall(w_stall), .flush(w_flush), .br_target(w_br_target),
        .inst_in(w_inst_in), .imem_addr(w_imem_addr), .pc(w_pc), .id_pc(w_id_pc),
        .id_inst(w_id_inst), .id_valid(w_id_valid), .halted(w_halted), .fetch_count(w_fetch_count)
    );

    assign inst_in   = imem[imem_addr];
    assign w_inst_in = wmem[w_imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'hA000_0000 | 32'(i);
            wmem[i] = 32'hB000_0000 | 32'(i);
        end
        imem[0] = 32'd11; imem[1] = 32'd22; imem[2] = 32'd33; imem[3] = 32'd44;
        imem[5] = 32'd0;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_target = 32'd0;
        w_rst = 1'b1; w_stall = 1'b0; w_flush = 1'b0; w_br_target = 32'd0;

        // Reset state
        step();
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_idpc", id_pc, 32'd0);
        chk("rst_cnt", 32'(fetch_count), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);

        // Straight-line fetch of words 0..3
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("line_inst", id_inst, 32'd11 * 32'(i + 1));
            chk("line_idpc", id_pc, 32'(i));
            chk("line_valid", 32'(id_valid), 32'd1);
            chk("line_pc", pc, 32'(i + 1));
        end
        chk("line_cnt", 32'(fetch_count), 32'd4);

        // Re-reset after activity, then stall at pc=2
        rst = 1'b1;
        step();
        chk("rerst_pc", pc, 32'd0);
        chk("rerst_cnt", 32'(fetch_count), 32'd0);
        rst = 1'b0;
        step();
        step();
        chk("pre_stall_pc", pc, 32'd2);
        chk("pre_stall_inst", id_inst, 32'd22);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_pc", pc, 32'd2);
            chk("stall_inst", id_inst, 32'd22);
            chk("stall_idpc", id_pc, 32'd1);
            chk("stall_cnt", 32'(fetch_count), 32'd2);
        end
        stall = 1'b0;
        step();
        chk("post_stall_inst", id_inst, 32'd33);
        chk("post_stall_idpc", id_pc, 32'd2);
        chk("post_stall_pc", pc, 32'd3);
        chk("post_stall_cnt", 32'(fetch_count), 32'd3);

        // Flush at pc=3 to 40
        flush = 1'b1; br_target = 32'd40;
        step();
        chk("flush_pc", pc, 32'd40);
        chk("flush_valid", 32'(id_valid), 32'd0);
        chk("flush_inst", id_inst, 32'd0);
        chk("flush_idpc", id_pc, 32'd0);
        chk("flush_cnt", 32'(fetch_count), 32'd3);
        flush = 1'b0;
        step();
        chk("after_flush_idpc", id_pc, 32'd40);
        chk("after_flush_valid", 32'(id_valid), 32'd1);
        chk("after_flush_inst", id_inst, 32'hA000_0028);
        chk("after_flush_cnt", 32'(fetch_count), 32'd4);

        // Flush and stall together: flush wins
        flush = 1'b1; stall = 1'b1; br_target = 32'd7;
        step();
        chk("fs_pc", pc, 32'd7);
        chk("fs_valid", 32'(id_valid), 32'd0);
        flush = 1'b0; stall = 1'b0;
        step();
        chk("fs_next_inst", id_inst, 32'hA000_0007);
        chk("fs_next_pc", pc, 32'd8);
        chk("fs_next_cnt", 32'(fetch_count), 32'd5);

        // Halt: stall outranks halt detect, then halt word at pc=5
        flush = 1'b1; br_target = 32'd4;
        step();
        flush = 1'b0;
        step();
        chk("pre_halt_pc", pc, 32'd5);
        chk("pre_halt_cnt", 32'(fetch_count), 32'd6);
        stall = 1'b1;
        step();
        chk("stall_halt_halted", 32'(halted), 32'd0);
        chk("stall_halt_inst", id_inst, 32'hA000_0004);
        stall = 1'b0;
        step();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", pc, 32'd5);
        chk("halt_valid", 32'(id_valid), 32'd0);
        chk("halt_inst", id_inst, 32'd0);
        chk("halt_cnt", 32'(fetch_count), 32'd6);
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom_range(0, 1));
            step();
            chk("halted_hold", 32'(halted), 32'd1);
            chk("halted_pc", pc, 32'd5);
            chk("halted_valid", 32'(id_valid), 32'd0);
            chk("halted_cnt", 32'(fetch_count), 32'd6);
        end
        stall = 1'b0; flush = 1'b1; br_target = 32'd0;
        step();
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_pc", pc, 32'd0);
        flush = 1'b0;
        step();
        chk("unhalt_inst", id_inst, 32'd11);
        chk("unhalt_idpc", id_pc, 32'd0);

        // 32-bit PC wrap
        flush = 1'b1; br_target = 32'hFFFF_FFFF;
        step();
        chk("top_addr", 32'(imem_addr), 32'd255);
        flush = 1'b0;
        step();
        chk("pcwrap_pc", pc, 32'd0);
        chk("pcwrap_idpc", id_pc, 32'hFFFF_FFFF);
        chk("pcwrap_inst", id_inst, 32'hA000_00FF);

        // Second instance: imem_addr wrap from RESET_PC=254
        chk("w_rst_pc", w_pc, 32'd254);
        chk("w_rst_addr", 32'(w_imem_addr), 32'd254);
        w_rst = 1'b0;
        step();
        chk("w_addr_255", 32'(w_imem_addr), 32'd255);
        chk("w_inst_254", w_id_inst, 32'hB000_00FE);
        step();
        chk("w_pc_256", w_pc, 32'd256);
        chk("w_addr_0", 32'(w_imem_addr), 32'd0);
        chk("w_inst_255", w_id_inst, 32'hB000_00FF);
        step();
        chk("w_inst_0", w_id_inst, 32'hB000_0000);
        chk("w_idpc_256", w_id_pc, 32'd256);
        w_stall = 1'b1;
        step();
        chk("w_stall_pc", w_pc, 32'd257);
        w_rst = 1'b1;
        step();
        chk("w_rststall_pc", w_pc, 32'd254);
        chk("w_rststall_cnt", 32'(w_fetch_count), 32'd0);
        chk("w_rststall_valid", 32'(w_id_valid), 32'd0);

        // fetch_count saturation
        w_rst = 1'b0; w_stall = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_reach", 32'(w_fetch_count), 32'h0000_FFFF);
        step();
        step();
        chk("sat_hold", 32'(w_fetch_count), 32'h0000_FFFF);
        chk("sat_pc", w_pc, 32'd254 + 32'd65537);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'd0, word address loaded into the PC on reset.
REQ-002 Parameter: HALT_WORD, 32'h0000_0000, instruction encoding that halts fetch.
REQ-003 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  in  1  reset; synchronous and active-high.
REQ-005 Port: stall  in  1  hold request from the hazard logic; freezes the PC and the IF/ID register.
REQ-006 Port: flush  in  1  taken branch or jump; redirects the PC and kills the IF/ID contents.
REQ-007 Port: br_target  in  32  word-addressed redirect target, sampled when flush=1.
REQ-008 Port: inst_in  in  32  instruction from the 256x32 instruction memory; combinational read of imem_addr.
REQ-009 Port: imem_addr  out  8  instruction memory address; equals pc[7:0]; combinational.
REQ-010 Port: pc  out  32  current fetch PC; registered.
REQ-011 Port: id_pc  out  32  IF/ID register: PC of the held instruction.
REQ-012 Port: id_inst  out  32  IF/ID register: instruction passed to decode, the immediate generator and the register file.
REQ-013 Port: id_valid  out  1  IF/ID register: id_inst is a real instruction.
REQ-014 Port: halted  out  1  1 while the FSM is in HALTED.
REQ-015 Port: fetch_count  out  16  number of instructions issued to IF/ID; saturates.

Function
REQ-016 The block SHALL implement a two-state FSM, RUN and HALTED.
REQ-017 Each cycle SHALL take exactly one action, in priority order: rst, flush, stall, halt detect, normal fetch.
REQ-018 Flush (either state): pc <= br_target; id_valid <= 0; id_inst <= 0; id_pc <= 0; state <= RUN; fetch_count unchanged.
REQ-019 Stall (RUN, no flush): pc, id_pc, id_inst, id_valid and fetch_count SHALL all hold.
REQ-020 Halt detect (RUN, no flush, no stall, inst_in == HALT_WORD): pc holds; id_valid <= 0; id_inst <= 0; state <= HALTED; fetch_count unchanged; the halt word SHALL NOT be issued.
REQ-021 Normal fetch (RUN, no flush, no stall, inst_in != HALT_WORD): id_inst <= inst_in; id_pc <= pc; id_valid <= 1; pc <= pc + 1 (32-bit, wraps at 2^32); fetch_count <= fetch_count + 1.
REQ-022 fetch_count SHALL saturate at 16'hFFFF.
REQ-023 HALTED without flush: all registers SHALL hold, id_valid SHALL stay 0, and stall SHALL be ignored.
REQ-024 The PC is word-addressed: increments are +1 and br_target is used unshifted.
REQ-025 imem_addr SHALL be pc[7:0], so PC 255 -> 256 wraps the address to 0 with no other effect.
REQ-026 Flush and stall asserted together: flush wins and the stall is dropped.
REQ-027 Fetch latency: an instruction at address A SHALL appear on id_inst one cycle after pc == A with no stall.
REQ-028 When a stall ends, the first normal cycle SHALL issue the instruction at the held pc, so no instruction is lost or duplicated.

Reset
REQ-029 With rst=1 at posedge clk: pc <= RESET_PC; id_pc <= 0; id_inst <= 0; id_valid <= 0; fetch_count <= 0; state <= RUN; halted <= 0.
REQ-030 rst SHALL override flush, stall and halt in the same cycle.
REQ-031 rst asserted mid-stall or while HALTED SHALL return the block to RUN at RESET_PC on the next edge.
REQ-032 Before the first reset edge the outputs are undefined; the bench SHALL assert rst for at least 1 cycle.

Verification
REQ-033 Straight-line fetch: reset; memory words 0..3 = 11,22,33,44 -> id_inst sequence 11,22,33,44 with id_pc 0..3; id_valid=1 from cycle 2; fetch_count=4.
REQ-034 Stall: assert stall for 2 cycles while pc=2 -> pc stays 2, id_inst stays 22; after release id_inst=33, id_pc=2; no duplicate is issued.
REQ-035 Flush: at pc=3 assert flush with br_target=40 -> next cycle pc=40, id_valid=0; following cycle id_pc=40, id_valid=1.
REQ-036 Flush plus stall in the same cycle, br_target=7 -> pc=7, id_valid=0, stall ignored.
REQ-037 Halt: memory word 5 = 0 -> at pc=5 halted=1, pc stays 5, id_valid=0 for 10 cycles under random stall; then flush with br_target=0 -> halted=0, pc=0.
REQ-038 Wrap and reset: run from RESET_PC=254 -> imem_addr goes 254,255,0 while pc=256; assert rst while stalled -> pc=254, fetch_count=0, id_valid=0.
